// File: rtl/aes_key_schedule_ctrl.sv
// aes_key_schedule_ctrl
//
// Sequencer and round-key store wrapped around an external KeyExpansion
// block.
//
// On an accepted start the cipher key becomes round key 0. KeyExpansion is
// then stepped through rounds 1..NR. Each returned round key is stored and
// also fed back as the input for the next round. All NR+1 keys stay in
// storage, and a registered read port serves them to the round datapath.
//
// Ports:
//   clk_i           system clock, rising edge
//   rst_ni          asynchronous active-low reset
//   start_i         request expansion of cipher_key_i (honoured in IDLE/DONE only)
//   cipher_key_i    128-bit AES key, row-major state layout (bits 0..31 = row 0)
//   busy_o          high while an expansion is in progress
//   done_o          one-cycle pulse once round key NR has been stored
//   keys_valid_o    high while every stored key belongs to the last accepted key
//   ke_keyInit_o    round index driven to KeyExpansion
//   ke_key_o        previous round key driven to KeyExpansion
//   ke_roundKey_i   round key returned by KeyExpansion
//   rd_idx_i        index of the round key to read (0..NR, larger reads 0)
//   rd_key_o        registered read data, one cycle after rd_idx_i
module aes_key_schedule_ctrl #(
    parameter int KE_LATENCY = 1,
    parameter int NR         = 10
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [0:127] cipher_key_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         keys_valid_o,
    output logic [0:3]   ke_keyInit_o,
    output logic [0:127] ke_key_o,
    input  logic [0:127] ke_roundKey_i,
    input  logic [3:0]   rd_idx_i,
    output logic [0:127] rd_key_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] LAT   = 3'(KE_LATENCY);
    localparam logic [3:0] LAST  = 4'(NR);

    state_t         state_q;
    logic [0:127]   rk_q [0:NR];
    logic [3:0]     r_q;
    logic [2:0]     cnt_q;
    logic           busy_q;
    logic           done_q;
    logic           keys_valid_q;
    logic [0:3]     ke_keyInit_q;
    logic [0:127]   ke_key_q;
    logic [0:127]   rd_key_q;
    logic [0:127]   rd_key_d;

    // Read mux: indices beyond the last round key read as zero.
    always_comb begin
        rd_key_d = '0;
        if (rd_idx_i <= LAST) begin
            rd_key_d = rk_q[rd_idx_i];
        end
    end

    // Controller, key store and all registered outputs.
    //
    // The KeyExpansion inputs are registered. They change on the same edge
    // that advances r_q, so the external block sees stable inputs for the
    // whole round. Outside RUN they fall back to the pass-through round:
    // keyInit = 0 and key = rk[0].
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            r_q          <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            keys_valid_q <= 1'b0;
            ke_keyInit_q <= '0;
            ke_key_q     <= '0;
            rd_key_q     <= '0;
            for (int i = 0; i <= NR; i++) begin
                rk_q[i] <= '0;
            end
        end else begin
            done_q   <= 1'b0;
            rd_key_q <= rd_key_d;
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        rk_q[0]      <= cipher_key_i;
                        r_q          <= 4'd1;
                        cnt_q        <= '0;
                        keys_valid_q <= 1'b0;
                        busy_q       <= 1'b1;
                        ke_keyInit_q <= 4'd1;
                        ke_key_q     <= cipher_key_i;
                        state_q      <= RUN;
                    end else begin
                        ke_keyInit_q <= '0;
                        ke_key_q     <= rk_q[0];
                    end
                end
                RUN: begin
                    if (cnt_q != LAT) begin
                        cnt_q <= cnt_q + 3'd1;
                    end else begin
                        // KeyExpansion output has settled for this round.
                        cnt_q     <= '0;
                        rk_q[r_q] <= ke_roundKey_i;
                        if (r_q != LAST) begin
                            r_q          <= r_q + 4'd1;
                            ke_keyInit_q <= r_q + 4'd1;
                            ke_key_q     <= ke_roundKey_i;
                        end else begin
                            state_q      <= DONE;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                            keys_valid_q <= 1'b1;
                            ke_keyInit_q <= '0;
                            ke_key_q     <= rk_q[0];
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign keys_valid_o = keys_valid_q;
    assign ke_keyInit_o = ke_keyInit_q;
    assign ke_key_o     = ke_key_q;
    assign rd_key_o     = rd_key_q;

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// tb_aes_key_schedule_ctrl
//
// Exercises two controllers side by side with shared stimulus.
// - dut1 uses KE_LATENCY=1.
// - dut3 uses KE_LATENCY=3.
//
// Each controller is paired with a behavioural KeyExpansion. That model
// computes the real AES-128 key-schedule step and delays it by the matching
// number of clock edges. Expected round keys come from iterating the same
// key-schedule step from the cipher key.
module tb_aes_key_schedule_ctrl;

    logic         clk = 1'b0;
    logic         rstN;
    logic         start;
    logic [0:127] cipherKey;
    logic [3:0]   rdIdx;

    logic         busy1, done1, kv1;
    logic [0:3]   keyInit1;
    logic [0:127] keKey1, roundKey1, rdKey1;

    logic         busy3, done3, kv3;
    logic [0:3]   keyInit3;
    logic [0:127] keKey3, roundKey3, rdKey3;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [7:0]   sboxTab [256];
    logic [127:0] expKeys [0:10];

    logic [127:0] pipe1;
    logic [127:0] pipe3 [0:2];

    always #5 clk = ~clk;

    aes_key_schedule_ctrl #(.KE_LATENCY(1), .NR(10)) dut1 (
        .clk_i(clk), .rst_ni(rstN), .start_i(start), .cipher_key_i(cipherKey),
        .busy_o(busy1), .done_o(done1), .keys_valid_o(kv1),
        .ke_keyInit_o(keyInit1), .ke_key_o(keKey1), .ke_roundKey_i(roundKey1),
        .rd_idx_i(rdIdx), .rd_key_o(rdKey1)
    );

    aes_key_schedule_ctrl #(.KE_LATENCY(3), .NR(10)) dut3 (
        .clk_i(clk), .rst_ni(rstN), .start_i(start), .cipher_key_i(cipherKey),
        .busy_o(busy3), .done_o(done3), .keys_valid_o(kv3),
        .ke_keyInit_o(keyInit3), .ke_key_o(keKey3), .ke_roundKey_i(roundKey3),
        .rd_idx_i(rdIdx), .rd_key_o(rdKey3)
    );

    // GF(2^8) multiply with the AES polynomial.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    // S-box built from the multiplicative inverse and the affine map.
    initial begin
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sboxTab[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    end

    // One AES-128 key-schedule round on a row-major packed key.
    function automatic logic [127:0] keyStep(input logic [127:0] prev, input int rnd);
        logic [31:0]  w [4];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [127:0] res;
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++)
                w[j][31-8*i -: 8] = prev[127-8*(4*i+j) -: 8];
        t = {w[3][23:0], w[3][31:24]};
        t = {sboxTab[t[31:24]], sboxTab[t[23:16]], sboxTab[t[15:8]], sboxTab[t[7:0]]};
        rc = 8'h01;
        for (int i = 1; i < rnd; i++) rc = gmul(rc, 8'h02);
        t = t ^ {rc, 24'h0};
        w[0] = w[0] ^ t;
        w[1] = w[1] ^ w[0];
        w[2] = w[2] ^ w[1];
        w[3] = w[3] ^ w[2];
        res = '0;
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++)
                res[127-8*(4*i+j) -: 8] = w[j][31-8*i -: 8];
        return res;
    endfunction

    function automatic logic [127:0] keModel(input logic [127:0] key, input logic [3:0] idx);
        return (idx == 4'd0) ? key : keyStep(key, int'(idx));
    endfunction

    // Behavioural KeyExpansion instances with 1 and 3 edges of latency.
    always @(posedge clk) begin
        pipe1    <= keModel(keKey1, keyInit1);
        pipe3[0] <= keModel(keKey3, keyInit3);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign roundKey1 = pipe1;
    assign roundKey3 = pipe3[2];

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] randKey();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Every output must read zero while reset is asserted.
    task automatic checkZeroed(input string tag);
        checkOutput({tag, "_busy1"}, 128'(busy1), 128'h0);
        checkOutput({tag, "_done1"}, 128'(done1), 128'h0);
        checkOutput({tag, "_kv1"}, 128'(kv1), 128'h0);
        checkOutput({tag, "_keyInit1"}, 128'(keyInit1), 128'h0);
        checkOutput({tag, "_keKey1"}, keKey1, 128'h0);
        checkOutput({tag, "_rdKey1"}, rdKey1, 128'h0);
        checkOutput({tag, "_busy3"}, 128'(busy3), 128'h0);
        checkOutput({tag, "_kv3"}, 128'(kv3), 128'h0);
        checkOutput({tag, "_rdKey3"}, rdKey3, 128'h0);
    endtask

    // Read all 16 indices in a shuffled order and compare with the model.
    task automatic readCheck(input string tag);
        int off;
        int idx;
        logic [127:0] exp;
        off = int'($urandom_range(0, 15));
        for (int i = 0; i < 16; i++) begin
            idx = (i * 7 + off) % 16;
            rdIdx = 4'(idx);
            @(negedge clk);
            exp = (idx <= 10) ? expKeys[idx] : 128'h0;
            checkOutput($sformatf("%s_rd1_idx%0d", tag, idx), rdKey1, exp);
            checkOutput($sformatf("%s_rd3_idx%0d", tag, idx), rdKey3, exp);
        end
    endtask

    task automatic readOne(input int idx, input logic [127:0] exp);
        rdIdx = 4'(idx);
        @(negedge clk);
        checkOutput($sformatf("fips1_idx%0d", idx), rdKey1, exp);
        checkOutput($sformatf("fips3_idx%0d", idx), rdKey3, exp);
    endtask

    // Start one expansion and trace the handshake edge by edge.
    // - glitchAt: cycle at which a spurious start is raised (-1 for none).
    // - resetAt:  cycle at which reset is asserted mid-run (-1 for none).
    // Cycle c is sampled on the falling edge after the c-th rising edge
    // that follows the start edge. Called and returns on a falling edge.
    task automatic applyStimulus(input string tag, input logic [127:0] key,
                                 input int glitchAt, input int resetAt);
        expKeys[0] = key;
        for (int r = 1; r <= 10; r++) expKeys[r] = keyStep(expKeys[r-1], r);
        cipherKey = key;
        start = 1'b1;
        @(negedge clk);
        for (int c = 0; c <= 42; c++) begin
            if (c == resetAt) begin
                #2 rstN = 1'b0;
                #1 checkZeroed($sformatf("%s_rstmid", tag));
                @(negedge clk);
                rstN = 1'b1;
                start = 1'b0;
                for (int k = 0; k < 45; k++) begin
                    checkOutput($sformatf("%s_nodone1_%0d", tag, k), 128'(done1), 128'h0);
                    checkOutput($sformatf("%s_nodone3_%0d", tag, k), 128'(done3), 128'h0);
                    checkOutput($sformatf("%s_idle1_%0d", tag, k), 128'(busy1), 128'h0);
                    @(negedge clk);
                end
                for (int r = 0; r <= 10; r++) expKeys[r] = 128'h0;
                break;
            end
            if (c < 20) begin
                checkOutput($sformatf("%s_keyInit1_c%0d", tag, c), 128'(keyInit1), 128'(c / 2 + 1));
                checkOutput($sformatf("%s_keKey1_c%0d", tag, c), keKey1, expKeys[c / 2]);
                checkOutput($sformatf("%s_busy1_c%0d", tag, c), 128'(busy1), 128'h1);
                checkOutput($sformatf("%s_kv1_c%0d", tag, c), 128'(kv1), 128'h0);
                checkOutput($sformatf("%s_done1_c%0d", tag, c), 128'(done1), 128'h0);
            end else if (c == 20) begin
                checkOutput($sformatf("%s_done1_c%0d", tag, c), 128'(done1), 128'h1);
                checkOutput($sformatf("%s_busy1_c%0d", tag, c), 128'(busy1), 128'h0);
                checkOutput($sformatf("%s_kv1_c%0d", tag, c), 128'(kv1), 128'h1);
                checkOutput($sformatf("%s_keyInit1_c%0d", tag, c), 128'(keyInit1), 128'h0);
                checkOutput($sformatf("%s_keKey1_c%0d", tag, c), keKey1, expKeys[0]);
            end else begin
                checkOutput($sformatf("%s_done1_c%0d", tag, c), 128'(done1), 128'h0);
                checkOutput($sformatf("%s_kv1_c%0d", tag, c), 128'(kv1), 128'h1);
            end
            if (c < 40) begin
                checkOutput($sformatf("%s_keyInit3_c%0d", tag, c), 128'(keyInit3), 128'(c / 4 + 1));
                checkOutput($sformatf("%s_keKey3_c%0d", tag, c), keKey3, expKeys[c / 4]);
                checkOutput($sformatf("%s_busy3_c%0d", tag, c), 128'(busy3), 128'h1);
                checkOutput($sformatf("%s_done3_c%0d", tag, c), 128'(done3), 128'h0);
                checkOutput($sformatf("%s_kv3_c%0d", tag, c), 128'(kv3), 128'h0);
            end else begin
                checkOutput($sformatf("%s_done3_c%0d", tag, c), 128'(done3), 128'(c == 40));
                checkOutput($sformatf("%s_kv3_c%0d", tag, c), 128'(kv3), 128'h1);
                checkOutput($sformatf("%s_busy3_c%0d", tag, c), 128'(busy3), 128'h0);
            end
            // The cipher key input is scrambled once the start edge has passed.
            if (c == 0) cipherKey = randKey();
            if (c == glitchAt) begin
                start = 1'b1;
                cipherKey = randKey();
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rstN = 1'b1;
        start = 1'b0;
        cipherKey = '0;
        rdIdx = '0;

        // Asynchronous reset asserted mid-cycle, followed by a quiet idle period.
        repeat (2) @(negedge clk);
        #2 rstN = 1'b0;
        #1 checkZeroed("por");
        @(negedge clk);
        rstN = 1'b1;
        for (int k = 0; k < 10; k++) begin
            checkOutput($sformatf("idle_busy_%0d", k), 128'(busy1 | busy3), 128'h0);
            checkOutput($sformatf("idle_done_%0d", k), 128'(done1 | done3), 128'h0);
            @(negedge clk);
        end
        for (int r = 0; r <= 10; r++) expKeys[r] = 128'h0;
        readCheck("idle");

        // FIPS-197 appendix A.1 key.
        applyStimulus("fips", 128'h2B28AB097EAEF7CF15D2154F16A6883C, -1, -1);
        readOne(1,  128'ha088232afa54a36cfe2c397617b13905);
        readOne(9,  128'hac19285777fad15c66dc2900f321416e);
        readOne(10, 128'hd0c9e1b614ee3f63f9250c0ca889c8a6);
        readOne(0,  128'h2B28AB097EAEF7CF15D2154F16A6883C);
        readCheck("fips");

        // A spurious start during round 4 must be ignored.
        applyStimulus("glitch", randKey(), 6, -1);
        readCheck("glitch");

        // Restart from DONE with an all-zero key.
        applyStimulus("zero", 128'h0, -1, -1);
        readCheck("zero");

        // Reset asserted during round 6.
        applyStimulus("abort", randKey(), -1, 10);
        readCheck("abort");

        // A few more random keys.
        for (int n = 0; n < 3; n++) begin
            applyStimulus($sformatf("rand%0d", n), randKey(), -1, -1);
            readCheck($sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
